// File: rtl/fp_norm_round_pack_pkg.sv
// Shared widths, in_mant bit positions, FSM encoding and result payload for the FP-32 adder back end.
package fp_norm_round_pack_pkg;

    localparam int unsigned DATA_WIDTH         = 32;
    localparam int unsigned EXP_WIDTH          = 8;
    localparam int unsigned SIGNIFICANDS_WIDTH = 23;
    localparam int unsigned ADDER_WIDTH        = 25;

    // in_mant carries guard and sticky below the adder result
    localparam int unsigned MANT_WIDTH    = ADDER_WIDTH + 2;
    // one extra exponent bit so a carry past 254 is still visible
    localparam int unsigned EXP_INT_WIDTH = EXP_WIDTH + 1;
    // hidden bit + fraction
    localparam int unsigned SIG_WIDTH     = SIGNIFICANDS_WIDTH + 1;

    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned EXP_MAX  = 255;

    localparam int unsigned CARRY_BIT  = 26;
    localparam int unsigned HIDDEN_BIT = 25;
    localparam int unsigned FRAC_MSB   = 24;
    localparam int unsigned FRAC_LSB   = 2;
    localparam int unsigned GUARD_BIT  = 1;
    localparam int unsigned STICKY_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic                          sign;
        logic [EXP_WIDTH-1:0]          exp;
        logic [SIGNIFICANDS_WIDTH-1:0] frac;
    } fp32_t;

endpackage

// File: rtl/fp_norm_round_pack_if.sv
// Valid/ready handshake bundle: raw sum in, packed IEEE-754 single plus flags out.
interface fp_norm_round_pack_if;
    import fp_norm_round_pack_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic                  in_sign;
    logic [EXP_WIDTH-1:0]  in_exp;
    logic [MANT_WIDTH-1:0] in_mant;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_overflow;
    logic                  out_inexact;
    logic                  out_zero;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, out_data, out_overflow, out_inexact, out_zero
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, out_ready,
        output in_ready, out_valid, out_data, out_overflow, out_inexact, out_zero
    );

endinterface

// File: rtl/fp_round_nearest_even.sv
// Combinational round-to-nearest-even of a hidden+fraction significand.
module fp_round_nearest_even
    import fp_norm_round_pack_pkg::*;
(
    input  logic [SIG_WIDTH-1:0] sig,
    input  logic                 guard,
    input  logic                 sticky,
    output logic [SIG_WIDTH-1:0] rounded_c,
    output logic                 carry_c,
    output logic                 inexact_c
);

    logic round_up;

    // Round up on more-than-half, or exactly half with an odd LSB
    always_comb begin
        round_up               = guard & (sticky | sig[0]);
        {carry_c, rounded_c}   = {1'b0, sig} + (SIG_WIDTH + 1)'(round_up);
        inexact_c              = guard | sticky;
    end

endmodule

// File: rtl/fp_norm_round_pack.sv
// FP-32 adder back end: iterative normalize, round-nearest-even, pack with zero/denormal/overflow handling.
module fp_norm_round_pack
    import fp_norm_round_pack_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    fp_norm_round_pack_if.slave  bus
);

    state_t                     state_q, state_d;
    logic                       sign_q, sign_d;
    logic [EXP_INT_WIDTH-1:0]   exp_q, exp_d;
    logic [MANT_WIDTH-1:0]      mant_q, mant_d;
    logic                       zero_q, zero_d;

    logic                       in_ready_q, in_ready_d;
    logic                       out_valid_q, out_valid_d;
    fp32_t                      out_data_q, out_data_d;
    logic                       out_overflow_q, out_overflow_d;
    logic                       out_inexact_q, out_inexact_d;
    logic                       out_zero_q, out_zero_d;

    logic [SIG_WIDTH-1:0]       rounded_c;
    logic                       rnd_carry_c;
    logic                       rnd_inexact_c;

    logic [SIG_WIDTH-1:0]       sig_fin;
    logic [EXP_INT_WIDTH-1:0]   exp_fin;
    logic                       hidden_fin;

    fp_round_nearest_even u_round (
        .sig       (mant_q[HIDDEN_BIT:FRAC_LSB]),
        .guard     (mant_q[GUARD_BIT]),
        .sticky    (mant_q[STICKY_BIT]),
        .rounded_c (rounded_c),
        .carry_c   (rnd_carry_c),
        .inexact_c (rnd_inexact_c)
    );

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            sign_q         <= 1'b0;
            exp_q          <= '0;
            mant_q         <= '0;
            zero_q         <= 1'b0;
            in_ready_q     <= 1'b1;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_overflow_q <= 1'b0;
            out_inexact_q  <= 1'b0;
            out_zero_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            sign_q         <= sign_d;
            exp_q          <= exp_d;
            mant_q         <= mant_d;
            zero_q         <= zero_d;
            in_ready_q     <= in_ready_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_overflow_q <= out_overflow_d;
            out_inexact_q  <= out_inexact_d;
            out_zero_q     <= out_zero_d;
        end
    end

    // Next-state, normalization step, rounding/packing and handshake control
    always_comb begin
        state_d        = state_q;
        sign_d         = sign_q;
        exp_d          = exp_q;
        mant_d         = mant_q;
        zero_d         = zero_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_overflow_d = out_overflow_q;
        out_inexact_d  = out_inexact_q;
        out_zero_d     = out_zero_q;

        // A rounding carry leaves 1.000...0 and bumps the exponent
        sig_fin    = rnd_carry_c ? {1'b1, {SIGNIFICANDS_WIDTH{1'b0}}} : rounded_c;
        exp_fin    = exp_q + EXP_INT_WIDTH'(rnd_carry_c);
        hidden_fin = sig_fin[SIG_WIDTH-1];

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    sign_d  = bus.in_sign;
                    exp_d   = EXP_INT_WIDTH'(bus.in_exp);
                    mant_d  = bus.in_mant;
                    zero_d  = 1'b0;
                    state_d = ST_NORM;
                end
            end

            ST_NORM: begin
                if (mant_q[CARRY_BIT]) begin
                    // Dropped guard folds into sticky
                    mant_d  = {1'b0, mant_q[CARRY_BIT:FRAC_LSB],
                               mant_q[GUARD_BIT] | mant_q[STICKY_BIT]};
                    exp_d   = exp_q + EXP_INT_WIDTH'(1);
                    state_d = ST_ROUND;
                end else if (mant_q == '0) begin
                    zero_d  = 1'b1;
                    state_d = ST_ROUND;
                end else if (mant_q[HIDDEN_BIT] || (exp_q == EXP_INT_WIDTH'(1))) begin
                    state_d = ST_ROUND;
                end else begin
                    mant_d  = {mant_q[MANT_WIDTH-2:0], 1'b0};
                    exp_d   = exp_q - EXP_INT_WIDTH'(1);
                end
            end

            ST_ROUND: begin
                out_inexact_d  = rnd_inexact_c;
                out_overflow_d = 1'b0;
                out_zero_d     = 1'b0;
                if (zero_q) begin
                    out_data_d = '{sign: sign_q, exp: '0, frac: '0};
                    out_zero_d = 1'b1;
                end else if (hidden_fin && (exp_fin >= EXP_INT_WIDTH'(EXP_MAX))) begin
                    out_data_d     = '{sign: sign_q, exp: '1, frac: '0};
                    out_overflow_d = 1'b1;
                end else begin
                    out_data_d.sign = sign_q;
                    out_data_d.exp  = hidden_fin ? exp_fin[EXP_WIDTH-1:0] : '0;
                    out_data_d.frac = sig_fin[SIGNIFICANDS_WIDTH-1:0];
                    out_zero_d      = !hidden_fin && (sig_fin == '0);
                end
                state_d = ST_DONE;
            end

            ST_DONE: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_IDLE);
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_overflow = out_overflow_q;
    assign bus.out_inexact  = out_inexact_q;
    assign bus.out_zero     = out_zero_q;

endmodule

// File: doc/fp_norm_round_pack.md
Name: fp_norm_round_pack

Overview:
- Back end of the FP-32 adder datapath; the exponent-compare/align stage feeds the front end of the same datapath.
- Accepts the raw aligned-and-added significand with its sign and pre-normalization biased exponent.
- Normalizes iteratively (right shift on carry-out, left shift one bit per cycle on cancellation), rounds to nearest-even, handles zero/denormal/overflow and packs an IEEE-754 single.
- Valid/ready handshake on both sides; one operation in flight.

Parameters:
- DATA_WIDTH, 32, packed result width.
- EXP_WIDTH, 8, exponent field width.
- SIGNIFICANDS_WIDTH, 23, fraction field width.
- ADDER_WIDTH, 25, adder result width (carry + hidden + fraction); in_mant is ADDER_WIDTH+2 (adds guard, sticky).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept; high only in IDLE.
- in_sign  in  1  result sign.
- in_exp  in  EXP_WIDTH  biased exponent of hidden-bit position, range 1..254 (denormal sums presented with exp=1).
- in_mant  in  ADDER_WIDTH+2  [26] carry, [25] hidden, [24:2] fraction, [1] guard, [0] sticky.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  {sign, exp, fraction}.
- out_overflow  out  1  result is ±infinity from overflow.
- out_inexact  out  1  guard|sticky nonzero at rounding.
- out_zero  out  1  result is ±0.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, out_data=0, all flags=0. Reset mid-operation aborts; in_ready=1 the cycle after rst deasserts, and the in-flight result is never emitted.
- FSM IDLE -> NORM -> ROUND -> DONE -> IDLE.
- IDLE: on in_valid&in_ready, register sign/exp/mant and go to NORM.
- NORM, one decision per cycle, in priority order:
  - mant[26]=1: shift right 1, new sticky = old guard | old sticky | dropped bit; exp+1; go ROUND.
  - mant==0: zero flag; go ROUND.
  - mant[25]=1 or exp==1: go ROUND.
  - else: shift left 1 (zero fill), exp-1; stay in NORM.
- ROUND: round-up = G & (S | frac LSB).
  - Increment {hidden, fraction}; on carry out, shift right 1 and exp+1.
  - exp field = hidden ? exp : 0, so a denormal rounding up to hidden=1 gives exp field 1.
  - exp reaching 255 from either the carry path or the rounding path: out_data={sign,8'hFF,0}, out_overflow=1.
  - Zero: out_data={sign,31'b0}, out_zero=1.
  - out_inexact = G|S, evaluated before overflow substitution.
  - Assert out_valid next cycle; go to DONE.
- DONE: out_valid=1, out_data and flags stable until out_ready; on out_valid&out_ready go to IDLE and drop out_valid next cycle.
  - Back-to-back operations are not overlapped; in_ready is low from acceptance through DONE.
- Latency: accepted at edge T; out_valid high at T+3+k, where k = number of left shifts (0..24).
- Arithmetic: exponent register is EXP_WIDTH+1 bits internally so overflow is detected; left shift never takes exp below 1.

Decomposition:
- Shared package: width constants (EXP_WIDTH, SIGNIFICANDS_WIDTH, ADDER_WIDTH), bias 127, EXP_MAX 255, FSM state encoding, and the in_mant bit-position constants (carry, hidden, guard, sticky).
- One natural sub-module: fp_round_nearest_even, combinational. Takes hidden+fraction, G, S; returns rounded significand, carry-out and inexact.

Test Plan:
- 1.0+1.0: sign=0, exp=127, mant[26]=1, rest 0 -> out_data 0x40000000, out_valid at T+3, all flags 0.
- Cancellation: exp=130, only mant[22] set -> 3 left shifts -> 0x3F800000, out_valid at T+6.
- Tie-to-even:
  - exp=127, frac=0x7FFFFF, G=1, S=0 -> rounds up with carry -> 0x40000000, out_inexact=1.
  - frac=0x7FFFFE, G=1, S=0 -> 0x3FFFFFFE, out_inexact=1.
- Overflow: exp=254, mant[26]=1 -> 0x7F800000, out_overflow=1. Denormal: exp=1, only mant[24] set -> 0x00400000, no shift.
- Zero: sign=1, mant=0, exp=100 -> 0x80000000, out_zero=1, out_valid at T+3.
- Backpressure/reset:
  - Hold out_ready=0 for 5 cycles -> out_data stable and in_ready=0 throughout.
  - Assert rst during NORM (cancellation case) -> out_valid never rises; in_ready=1 the cycle after reset.
